// File: rtl/serial_add_sub_pkg.sv
// Shared types and defaults for the bit-serial adder/subtractor.
// State encodings and the default datapath width live here.
package serial_add_sub_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/result bundle between the ALU stage and the serial adder.
// The master drives the operands; the slave returns result and flags.
interface serial_add_sub_if
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, carry_out, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, carry_out, overflow, zero
    );

endinterface

// File: rtl/serial_add_sub_full_adder.sv
// Single-bit full adder built from elementary XOR/AND/OR gates.
// Reused every clock by the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic axb;
    logic ab;
    logic cx;

    xor g_x0 (axb, a, b);
    xor g_x1 (s, axb, cin);
    and g_a0 (ab, a, b);
    and g_a1 (cx, cin, axb);
    or  g_o0 (cout, ab, cx);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor, one bit per clock, LSB first.
// Result and flags update only on entry to DONE.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    serial_add_sub_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] ps;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             c_q;
    logic             a_msb;
    logic             b_msb;
    logic             co_q;
    logic             ov_q;
    logic             z_q;
    logic             s;
    logic             c_nx;
    logic             last;
    logic [WIDTH-1:0] fin;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (c_q),
        .s    (s),
        .cout (c_nx)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    // New bit enters at the MSB; after the last bit this is the full sum.
    assign fin  = {s, ps};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr  <= '0;
            b_sr  <= '0;
            ps    <= '0;
            cnt   <= '0;
            c_q   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            sum_q <= '0;
            co_q  <= 1'b0;
            ov_q  <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.sub ? ~bus.b : bus.b;
                        c_q   <= bus.sub;
                        cnt   <= '0;
                        ps    <= '0;
                        a_msb <= bus.a[WIDTH-1];
                        b_msb <= bus.b[WIDTH-1] ^ bus.sub;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    c_q  <= c_nx;
                    cnt  <= cnt + 1'b1;
                    ps   <= fin[WIDTH-1:1];
                    if (last) begin
                        sum_q <= fin;
                        co_q  <= c_nx;
                        ov_q  <= (a_msb == b_msb) && (s != a_msb);
                        z_q   <= (fin == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = co_q;
    assign bus.overflow  = ov_q;
    assign bus.zero      = z_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub with hand-computed expectations.
module tb_serial_add_sub;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic [15:0] prev_sum;

    serial_add_sub_if #(.WIDTH(16)) bus ();

    serial_add_sub #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic op(input string tag, input logic [15:0] ta,
                      input logic [15:0] tb2, input logic ts,
                      input logic [15:0] es, input logic ec,
                      input logic ev, input logic ez);
        int cyc;
        int nbusy;
        @(negedge clk);
        bus.a = ta;
        bus.b = tb2;
        bus.sub = ts;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        nbusy = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.busy === 1'b1) nbusy++;
            if (cyc == 4) begin
                bus.start = 1'b1;
                bus.a = 16'd100;
                bus.b = 16'd100;
                bus.sub = ~ts;
            end
            if (cyc == 5) bus.start = 1'b0;
            if (cyc == 8) chk({tag, "_hold"}, 32'(bus.sum), 32'(prev_sum));
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'd17);
        chk({tag, "_nbusy"}, 32'(nbusy), 32'd16);
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
        chk({tag, "_cout"}, 32'(bus.carry_out), 32'(ec));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(ev));
        chk({tag, "_zero"}, 32'(bus.zero), 32'(ez));
        prev_sum = es;
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_held"}, 32'(bus.sum), 32'(es));
    endtask

    initial begin
        int np;
        int lastp;
        int nd;
        int w;
        n_cmp = 0;
        n_err = 0;
        prev_sum = 16'h0000;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_flags", 32'({bus.carry_out, bus.overflow, bus.zero}), 32'd0);

        op("add_3_5", 16'd3, 16'd5, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
        op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        op("sub_neg", 16'd5, 16'd7, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        op("sub_eq", 16'd9, 16'd9, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        op("add_ign", 16'd1, 16'd2, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        bus.a = 16'd1;
        bus.b = 16'd1;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        np = 0;
        lastp = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                np++;
                chk("b2b_sum", 32'(bus.sum), 32'd2);
                if (lastp >= 0) chk("b2b_gap", 32'(i - lastp), 32'd18);
                lastp = i;
            end
        end
        bus.start = 1'b0;
        chk("b2b_pulses", 32'(np), 32'd2);
        w = 0;
        while ((bus.busy === 1'b1 || bus.done === 1'b1) && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("b2b_drain", 32'(w < 40), 32'd1);
        prev_sum = 16'd2;

        @(negedge clk);
        bus.a = 16'h1234;
        bus.b = 16'h1111;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_busy_pre", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_sum", 32'(bus.sum), 32'd0);
        chk("abort_flags",
            32'({bus.carry_out, bus.overflow, bus.zero}), 32'd0);
        nd = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) nd++;
        end
        chk("abort_quiet", 32'(nd), 32'd0);
        prev_sum = 16'h0000;
        op("after_abort", 16'h1234, 16'h1111, 1'b0, 16'h2345,
           1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
